frame_scanout: RTL and testbench

- Read-side client of the dual-clock frame VRAM. Runs in the pixel-clock domain and drives the VRAM read port.
- Generates 640x480@60 VGA timing. Fetches the 320x240 frame with 2x pixel/line replication and expands 8-bit RGB332 to 12-bit RGB.
- Double-buffers two frames in one VRAM. Front/back selection flips only at vblank, through a req/ack handshake with the game-logic writer.

---
 rtl/frame_pkg.sv | 41 ++++
 rtl/vga_timing_gen.sv | 53 +++++
 rtl/frame_scanout.sv | 140 ++++++++++++++
 tb/tb_frame_scanout.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared VGA timing constants, pixel/control types and the RGB332 expansion
// used by the frame scanout path.
package frame_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // 10 bits cover both the 800-clock line and the 525-line frame
  localparam int CNT_W = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

  typedef enum logic {IDLE, PENDING} swap_state_t;

  function automatic rgb12_t rgb332_to_rgb12(input logic [7:0] q);
    rgb12_t c;
    c.r = {q[7:5], q[7]};
    c.g = {q[4:2], q[4]};
    c.b = {q[1:0], q[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v counters with raw (undelayed) sync, active and frame markers.
module vga_timing_gen
  import frame_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
)(
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_end,
  output logic             frame_end,
  output logic             frame_start
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

  assign line_end  = (hcount == H_LAST);
  assign frame_end = line_end && (vcount == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= line_end ? '0 : hcount + 1'b1;
      if (line_end) vcount <= frame_end ? '0 : vcount + 1'b1;
    end
  end

  assign hsync  = !((hcount >= HS_BEG) && (hcount <= HS_END));
  assign vsync  = !((vcount >= VS_BEG) && (vcount <= VS_END));
  assign active = (hcount < H_ACT) && (vcount < V_ACT);
  // Gated by reset so the marker is quiet while held, and fires on the first clock after release
  assign frame_start = !reset && (hcount == '0) && (vcount == '0);

endmodule

// File: rtl/frame_scanout.sv
// Pixel-clock scanout: 2x-replicated fetch from a double-buffered VRAM, RGB332
// expansion, sync delay line and the vblank buffer-flip handshake.
module frame_scanout
  import frame_pkg::*;
#(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int DW       = 8,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int RD_LAT   = 1,
  localparam int AW      = $clog2(WIDTH * HEIGHT)
)(
  input  logic          clk,
  input  logic          reset,
  output logic [AW:0]   rd_addr,
  input  logic [DW-1:0] rd_q,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          front_buf,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b
);
  localparam int P = 2 + RD_LAT;
  localparam logic [CNT_W-1:0] V_FLIP      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST_STEP = CNT_W'(V_ACTIVE - 1);

  logic [CNT_W-1:0] hcount, vcount;
  logic             hs_raw, vs_raw, active, line_end, frame_end;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync      (hs_raw),
    .vsync      (vs_raw),
    .active     (active),
    .line_end   (line_end),
    .frame_end  (frame_end),
    .frame_start(frame_start)
  );

  // Source row advances every second display line; stop after the last row so the
  // base never points past the frame.
  logic [AW-1:0] line_base;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      line_base <= '0;
    else if (frame_end)
      line_base <= '0;
    else if (line_end && vcount[0] && (vcount < V_LAST_STEP))
      line_base <= line_base + AW'(WIDTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_addr <= '0;
    else if (active)
      rd_addr <= {front_buf, line_base + AW'(hcount[CNT_W-1:1])};
  end

  // Control delay line; the last stage drives the pins alongside the colour register
  ctl_t         ctl_now;
  ctl_t [P-1:0] ctl_pipe;
  assign ctl_now = '{hsync: hs_raw, vsync: vs_raw, blank: !active};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctl_pipe <= {P{CTL_IDLE}};
    else       ctl_pipe <= {ctl_pipe[P-2:0], ctl_now};
  end

  rgb12_t pix;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    pix <= '0;
    else if (ctl_pipe[P-2].blank) pix <= '0;
    else                          pix <= rgb332_to_rgb12(rd_q[7:0]);
  end

  assign hsync = ctl_pipe[P-1].hsync;
  assign vsync = ctl_pipe[P-1].vsync;
  assign blank = ctl_pipe[P-1].blank;
  assign vga_r = pix.r;
  assign vga_g = pix.g;
  assign vga_b = pix.b;

  // Swap handshake: only a rising request arms it, so a held request flips once
  swap_state_t state, state_nxt;
  logic        req_d, req_rise, flip_pt, flip;

  assign req_rise = swap_req && !req_d;
  assign flip_pt  = (hcount == '0) && (vcount == V_FLIP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_d     <= 1'b0;
      front_buf <= 1'b0;
    end else begin
      state <= state_nxt;
      req_d <= swap_req;
      if (flip) front_buf <= !front_buf;
    end
  end

  always_comb begin
    state_nxt = state;
    flip      = 1'b0;
    case (state)
      IDLE: begin
        if (flip_pt && req_rise) flip = 1'b1;
        else if (req_rise)       state_nxt = PENDING;
      end
      PENDING: begin
        if (flip_pt) begin
          flip      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign swap_ack = flip;

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout on a scaled-down raster, with a pin scoreboard
// fed by an independent counter/handshake model.
module tb_frame_scanout;
  localparam int W = 20, H = 12;
  localparam int HA = 40, HF = 4, HS = 8, HBP = 4;
  localparam int VA = 24, VF = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HF + HS + HBP;
  localparam int VT = VA + VF + VS + VBP;
  localparam int FT = HT * VT;
  localparam int AW = 8;
  localparam int P  = 3;

  typedef struct {
    int          h;
    int          v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [11:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [AW:0] rd_addr;
  logic [7:0]  rd_q;
  logic        swap_req, swap_ack, front_buf, frame_start;
  logic        hsync, vsync, blank;
  logic [3:0]  vga_r, vga_g, vga_b;

  always #5 clk = !clk;

  frame_scanout #(
    .WIDTH(W), .HEIGHT(H), .DW(8),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VBP),
    .RD_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_q(rd_q),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_buf(front_buf),
    .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .blank(blank),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  // VRAM: both buffers hold value = low byte of pixel index, one clock latency
  always @(posedge clk) rd_q <= rd_addr[7:0];

  int n_chk, n_fail;
  exp_t sb[$];
  int mh, mv, cyc, ph, pv;
  logic mfb, mpend, mreq_d, pfb;
  logic [31:0] exp_addr;
  int hs_run, vs_run, bl_run, act_cnt, hs_fall, fs_last;
  logic hs_prev, vs_prev, bl_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] expand(input int q);
    int r, g, b;
    r = ((q >> 5) << 1) | (q >> 7);
    g = (((q >> 2) & 7) << 1) | ((q >> 4) & 1);
    b = ((q & 3) << 2) | (q & 3);
    return 12'((r << 8) | (g << 4) | b);
  endfunction

  task automatic model_reset();
    exp_t e;
    mh = 0; mv = 0; mfb = 0; mpend = 0; mreq_d = 0; exp_addr = 0;
    ph = -1; pv = -1; pfb = 0;
    sb.delete();
    e.h = -1; e.v = -1; e.hs = 1; e.vs = 1; e.bl = 1; e.rgb = '0;
    for (int i = 0; i < P; i++) sb.push_back(e);
    hs_run = 0; vs_run = 0; bl_run = 0; act_cnt = 0;
    hs_fall = -1; fs_last = -1; hs_prev = 1; vs_prev = 1; bl_seen = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_blank"}, blank, 1);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_front_buf"}, front_buf, 0);
    chk({tag, "_swap_ack"}, swap_ack, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
  endtask

  // Called once per cycle while the DUT counters sit at model state (mh,mv)
  task automatic sample();
    exp_t e, o;
    int idx;
    logic act, at_flip, rise, exp_ack;
    act     = (mh < HA) && (mv < VA);
    at_flip = (mh == 0) && (mv == VA);
    rise    = swap_req && !mreq_d;
    exp_ack = at_flip && (mpend || rise);
    idx     = (mv / 2) * W + mh / 2;

    chk("frame_start", frame_start, (mh == 0 && mv == 0));
    chk("swap_ack", swap_ack, exp_ack);
    chk("front_buf", front_buf, mfb);
    chk("rd_addr", rd_addr, exp_addr);
    chk("addr_bound", (rd_addr[AW-1:0] < W * H), 1);
    if (ph == HA - 1 && pv == VA - 1)
      chk("last_addr", rd_addr, (32'(pfb) << AW) | (W * H - 1));

    e.h = mh; e.v = mv;
    e.hs = !(mh >= HA + HF && mh < HA + HF + HS);
    e.vs = !(mv >= VA + VF && mv < VA + VF + VS);
    e.bl = !act;
    e.rgb = act ? expand(idx & 255) : 12'h0;
    sb.push_back(e);
    o = sb.pop_front();
    chk("hsync", hsync, o.hs);
    chk("vsync", vsync, o.vs);
    chk("blank", blank, o.bl);
    chk("rgb", {vga_r, vga_g, vga_b}, o.rgb);
    // pixel (5,3) = index 65 = 0x41 -> r=4 g=0 b=5
    if (o.h >= 10 && o.h <= 11 && o.v >= 6 && o.v <= 7)
      chk("pix_5_3", {vga_r, vga_g, vga_b}, 12'h405);

    if (!hsync) hs_run++;
    else begin
      if (hs_run > 0) chk("hsync_width", hs_run, HS);
      hs_run = 0;
    end
    if (hs_prev && !hsync) begin
      if (hs_fall >= 0) chk("line_period", cyc - hs_fall, HT);
      hs_fall = cyc;
    end
    if (!vsync) vs_run++;
    else begin
      if (vs_run > 0) chk("vsync_width", vs_run, VS * HT);
      vs_run = 0;
    end
    if (vs_prev && !vsync) begin
      chk("active_count", act_cnt, HA * VA);
      act_cnt = 0;
    end
    if (!blank) act_cnt++;
    if (blank) bl_run++;
    else begin
      if (bl_seen && bl_run > 0) begin
        if (bl_run < HT) chk("hblank_len", bl_run, HT - HA);
        else             chk("vblank_len", bl_run, (VT - VA) * HT + (HT - HA));
      end
      bl_seen = 1;
      bl_run = 0;
    end
    if (frame_start) begin
      if (fs_last >= 0) chk("frame_period", cyc - fs_last, FT);
      fs_last = cyc;
    end
    hs_prev = hsync; vs_prev = vsync;

    ph = mh; pv = mv; pfb = mfb;
    if (act) exp_addr = (32'(mfb) << AW) | 32'(idx);
    if (exp_ack) begin mfb = !mfb; mpend = 0; end
    else if (rise) mpend = 1;
    mreq_d = swap_req;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else mh++;
    cyc++;
  endtask

  task automatic cycle(input logic req);
    @(posedge clk);
    #1 swap_req = req;
    @(negedge clk);
    sample();
  endtask

  task automatic run_until(input int h, input int v, input logic req);
    int n;
    n = 0;
    while (!(mh == h && mv == v)) begin
      if (n > 2 * FT) begin
        chk("run_until_timeout", 0, 1);
        break;
      end
      cycle(req);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    n_chk = 0; n_fail = 0; cyc = 0;
    reset = 1; swap_req = 0;
    repeat (3) @(negedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk);
    reset = 0;
    model_reset();
    #1 sample();

    // Normal swap: request raised mid-frame and held until acknowledged
    run_until(0, 10, 0);
    run_until(0, VA, 1);
    cycle(1);
    chk("ack_at_flip", swap_ack, 1);
    chk("fb_before_flip", front_buf, 0);
    cycle(0);
    chk("fb_after_flip", front_buf, 1);
    chk("ack_one_clock", swap_ack, 0);
    run_until(1, 0, 0);
    cycle(0);
    chk("buf1_base", rd_addr, 1 << AW);

    // Request rising on the flip cycle itself
    run_until(0, VA, 0);
    cycle(1);
    chk("ack_same_cycle", swap_ack, 1);
    cycle(0);
    chk("fb_same_cycle", front_buf, 0);

    // Request held across three frames flips exactly once
    run_until(0, 5, 0);
    acks = 0;
    repeat (3 * FT) begin
      cycle(1);
      if (swap_ack) acks++;
    end
    chk("held_one_flip", acks, 1);
    chk("held_fb", front_buf, 1);

    // Arm a pending swap, then reset asynchronously mid-line
    run_until(0, 8, 0);
    run_until(20, 10, 1);
    chk("pre_reset_fb", front_buf, 1);
    reset = 1;
    #1 check_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    swap_req = 0;
    reset = 0;
    model_reset();
    #1 sample();
    chk("fs_after_rst", frame_start, 1);
    chk("fb_after_rst", front_buf, 0);
    repeat (FT + 60) cycle(0);
    chk("no_stale_flip", front_buf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
